// File: rtl/conv_scheduler.sv
// Layer sequencer for a convolution engine: one input load, then an o-major / i-minor
// sweep of compute passes, streaming each finished output map before moving on.
module conv_scheduler #(
    parameter  int INPUT_IMAGES  = 1,
    parameter  int OUTPUT_IMAGES = 20,
    localparam int IW = (INPUT_IMAGES  > 1) ? $clog2(INPUT_IMAGES)  : 1,
    localparam int OW = (OUTPUT_IMAGES > 1) ? $clog2(OUTPUT_IMAGES) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          rx_go,
    input  logic          rx_done,
    output logic          cmp_go,
    output logic [OW-1:0] cmp_out_no,
    output logic [IW-1:0] cmp_in_no,
    output logic          cmp_first,
    output logic          cmp_last,
    input  logic          cmp_done,
    output logic          tx_go,
    input  logic          tx_done,
    output logic [OW:0]   maps_sent
);

    typedef enum logic [2:0] {
        IDLE,
        RX_WAIT,
        CMP_WAIT,
        TX_WAIT,
        DONE
    } state_t;

    localparam logic [IW-1:0] IN_LAST  = IW'(INPUT_IMAGES - 1);
    localparam logic [OW-1:0] OUT_LAST = OW'(OUTPUT_IMAGES - 1);
    localparam logic [IW-1:0] IN_ONE   = IW'(1);
    localparam logic [OW-1:0] OUT_ONE  = OW'(1);
    localparam logic [OW:0]   MAP_ONE  = (OW + 1)'(1);

    state_t state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            rx_go      <= 1'b0;
            cmp_go     <= 1'b0;
            tx_go      <= 1'b0;
            cmp_out_no <= '0;
            cmp_in_no  <= '0;
            maps_sent  <= '0;
        end else begin
            rx_go  <= 1'b0;
            cmp_go <= 1'b0;
            tx_go  <= 1'b0;
            done   <= 1'b0;
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                // Completion strobes are qualified with !go so a done arriving in
                // the same cycle as its own go pulse cannot close the pass early.
                case (state)
                    IDLE: begin
                        if (start) begin
                            state      <= RX_WAIT;
                            busy       <= 1'b1;
                            rx_go      <= 1'b1;
                            cmp_out_no <= '0;
                            cmp_in_no  <= '0;
                            maps_sent  <= '0;
                        end
                    end
                    RX_WAIT: begin
                        if (rx_done && !rx_go) begin
                            state  <= CMP_WAIT;
                            cmp_go <= 1'b1;
                        end
                    end
                    CMP_WAIT: begin
                        if (cmp_done && !cmp_go) begin
                            if (cmp_in_no != IN_LAST) begin
                                cmp_in_no <= cmp_in_no + IN_ONE;
                                cmp_go    <= 1'b1;
                            end else begin
                                state <= TX_WAIT;
                                tx_go <= 1'b1;
                            end
                        end
                    end
                    TX_WAIT: begin
                        if (tx_done && !tx_go) begin
                            maps_sent <= maps_sent + MAP_ONE;
                            cmp_in_no <= '0;
                            if (cmp_out_no != OUT_LAST) begin
                                cmp_out_no <= cmp_out_no + OUT_ONE;
                                state      <= CMP_WAIT;
                                cmp_go     <= 1'b1;
                            end else begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Bias-seed and ReLU flags follow the registered input index directly.
    assign cmp_first = (cmp_in_no == '0);
    assign cmp_last  = (cmp_in_no == IN_LAST);

endmodule
